// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with single-line burst refill.
// Hits return data combinationally; misses stall the fetch stage until the
// line has been refilled and the re-lookup in IDLE hits.
module inst_cache #(
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_inst,
    output logic        cpu_stall_req,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned LINES    = 2 ** INDEX_W;
    localparam int unsigned WORDS    = 2 ** OFFSET_W;
    localparam int unsigned LINE_LSB = OFFSET_W + 2;
    localparam int unsigned TAG_LSB  = LINE_LSB + INDEX_W;
    localparam int unsigned TAG_W    = 32 - TAG_LSB;
    localparam int unsigned ADDR_W   = INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         data_q [LINES*WORDS];
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINES-1:0]    valid_q;
    logic [OFFSET_W-1:0] beat_q;
    logic                inv_pending_q;
    logic [31:0]         mem_addr_q;

    logic [OFFSET_W-1:0] cpu_off;
    logic [INDEX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  ref_idx;
    logic [TAG_W-1:0]    ref_tag;
    logic                hit;
    logic                miss_c;
    logic                refill_beat;
    logic                refill_done;
    logic                unused_ok;

    assign cpu_off   = cpu_addr[LINE_LSB-1:2];
    assign cpu_idx   = cpu_addr[TAG_LSB-1:LINE_LSB];
    assign cpu_tag   = cpu_addr[31:TAG_LSB];
    assign ref_idx   = mem_addr_q[TAG_LSB-1:LINE_LSB];
    assign ref_tag   = mem_addr_q[31:TAG_LSB];
    assign unused_ok = ^cpu_addr[1:0];

    // Lookup; everything forced quiet while reset is held.
    assign hit         = !rst && cpu_en && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign cpu_inst    = hit ? data_q[ADDR_W'({cpu_idx, cpu_off})] : 32'h0;
    assign miss_c      = (state_q == S_IDLE) && cpu_en && !hit;
    assign refill_beat = !rst && (state_q == S_REFILL) && mem_rvalid;
    assign refill_done = refill_beat && (beat_q == LAST_BEAT);
    assign mem_addr    = mem_addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (miss_c) state_d = S_REQ;
            S_REQ:    if (mem_gnt) state_d = S_REFILL;
            S_REFILL: if (refill_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: stall is immediate on a miss and held for the whole refill.
    always_comb begin
        cpu_stall_req = 1'b0;
        mem_req       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:   cpu_stall_req = cpu_en && !hit;
                S_REQ:    begin cpu_stall_req = 1'b1; mem_req = 1'b1; end
                S_REFILL: cpu_stall_req = 1'b1;
                default:  cpu_stall_req = 1'b0;
            endcase
        end
    end

    // Control state: valid bits, refill address, beat counter, deferred invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            beat_q        <= '0;
            inv_pending_q <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inv)    valid_q    <= '0;
                    if (miss_c) mem_addr_q <= {cpu_addr[31:LINE_LSB], LINE_LSB'(0)};
                end
                S_REQ: begin
                    if (inv) inv_pending_q <= 1'b1;
                    if (mem_gnt) begin
                        beat_q           <= '0;
                        // line contents are about to be overwritten
                        valid_q[ref_idx] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_rvalid) beat_q <= beat_q + OFFSET_W'(1);
                    if (refill_done) begin
                        if (inv_pending_q || inv) begin
                            valid_q       <= '0;
                            inv_pending_q <= 1'b0;
                        end else begin
                            valid_q[ref_idx] <= 1'b1;
                        end
                    end else if (inv) begin
                        inv_pending_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tag storage, written only by refill beats.
    always_ff @(posedge clk) begin
        if (refill_beat) data_q[ADDR_W'({ref_idx, beat_q})] <= mem_rdata;
        if (refill_done) tag_q[ref_idx] <= ref_tag;
    end

endmodule
